freq_gate_counter: RTL and testbench
====================================

# freq_gate_counter

Edge-counting frequency measurement stage. It sits directly downstream of the 24-way channel multiplexer and consumes that block's `out_wave`. It synchronises the selected chip output into the `Clock` domain and counts its rising edges over a programmable gate window of `Clock` cycles. It returns the count to the controller through a start/done handshake.

## Interface
Parameters:
- `COUNT_WIDTH`, default 24: width of the edge counter and result.
- `GATE_WIDTH`, default 32: width of the gate-length input.

Ports:
- `Clock`  in  1  system clock; every register is clocked on its rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `in_wave`  in  1  asynchronous measured signal from the mux `out_wave`.
- `start`  in  1  request a measurement; sampled only in IDLE.
- `abort`  in  1  cancel a measurement in progress.
- `gate_cycles`  in  GATE_WIDTH  gate length in `Clock` cycles; latched when `start` is accepted.
- `busy`  out  1  high in SETTLE and GATE.
- `done`  out  1  one-cycle pulse when `freq_count` is updated.
- `freq_count`  out  COUNT_WIDTH  rising edges counted in the last completed gate.
- `overflow`  out  1  last completed gate saturated the counter.

## Operation
- Synchroniser: two flip-flops `s1` and `s2` on `in_wave`, followed by history register `prev`. All three update every cycle in every state.
- `rise` is defined as `s2 & ~prev`.
- States and transitions:
  - IDLE: `start`=1 latches `gate_cycles` into the gate timer, clears the edge counter and the overflow accumulator, then moves to SETTLE.
  - SETTLE: stays exactly 2 cycles, then moves to GATE, or to DONE if the latched gate value is 0. This flushes stale synchroniser state left over from a mux channel change. `rise` is ignored here.
  - GATE: stays exactly N cycles, N being the latched value. Each cycle with `rise`=1 increments the counter. The cycle in which the timer reaches its last count moves to DONE.
  - DONE: lasts one cycle. `done`=1. `freq_count` and `overflow` load from the counter and accumulator at the edge entering DONE. The next state is IDLE.
- Counter saturates at 2^COUNT_WIDTH−1. A `rise` seen at saturation sets the overflow accumulator. The accumulator is sticky until the next accepted `start`.
- `abort`=1 in SETTLE or GATE returns to IDLE on the next edge:
  - no `done` pulse;
  - `freq_count` and `overflow` keep their previous values.
- `abort` has priority over GATE completion.
- `abort` in IDLE or DONE has no effect.
- `start` outside IDLE is ignored. This includes `start` in the DONE cycle; the requester must wait for `busy`=0 and `done`=0.
- `start` and `abort` asserted together in IDLE: `start` wins.
- `gate_cycles` changes after acceptance do not affect the running gate.

## Timing
- Reset values while `nReset`=0:
  - state IDLE;
  - `s1`, `s2`, `prev`, counter, timer, accumulator all 0;
  - `busy`=0, `done`=0, `freq_count`=0, `overflow`=0.
- Reset mid-measurement discards the measurement immediately, without a `done` pulse.
- `start` high in cycle T:
  - `busy` is high in cycles T+1 … T+2+N;
  - `done` is high in cycle T+3+N only;
  - `busy` is low in the `done` cycle.
- Pin-to-`rise` latency is 2–3 cycles. The counted window is therefore offset by a constant 2 cycles but is exactly N cycles long.
- Exact counting requires an `in_wave` high time and low time each ≥ 1 `Clock` period plus synchroniser margin. Faster inputs undercount, with no flag raised.
- Outputs are registered. No combinational path runs from inputs to outputs.

## Test plan
- **Basic count:** `Clock` 20 ns, `in_wave` period 200 ns (50% duty), `gate_cycles`=1000, `start` pulse.
  - `done` one cycle, 1003 cycles after the start cycle.
  - `freq_count`=100 (±1 by phase), `overflow`=0.
- **Zero and short gates:**
  - `gate_cycles`=0: `done` at T+3, `freq_count`=0.
  - `gate_cycles`=1 with `in_wave` held high from before `start`: `freq_count`=0, since there is no false edge after SETTLE.
- **Saturation:** `COUNT_WIDTH`=4, `in_wave` period 4 cycles, `gate_cycles`=100.
  - `freq_count`=15, `overflow`=1.
  - A following run with `gate_cycles`=20: `freq_count`=5, `overflow`=0.
- **Abort:**
  - Run 1 completes with `freq_count`=100.
  - Run 2 has `abort` at gate cycle 500.
  - Required: `busy` falls next cycle, no `done` pulse, `freq_count` still 100.
  - Also drive `start`+`abort` together in IDLE: the measurement starts.
- **Ignored start:**
  - `start` re-pulsed during GATE and in the DONE cycle: no restart, and the timing of the single `done` is unchanged.
  - `gate_cycles` changed mid-gate: the window length is unchanged.
- **Async reset:** `nReset` low for 3 ns mid-GATE, not aligned to `Clock`.
  - All outputs go to 0 immediately, the state returns to IDLE, and no `done` pulse occurs.
  - A subsequent `start` measures correctly.

Source files
------------

// File: rtl/freq_gate_counter.sv
`timescale 1ns/1ps
// freq_gate_counter
//
// Edge-counting frequency measurement stage. The asynchronous in_wave is
// brought into the Clock domain through a two-flop synchroniser plus a
// history flop, and its rising edges are counted over a programmable gate
// window of Clock cycles. A start/done handshake returns the count.
//
// Ports:
//   Clock        system clock, all registers on its rising edge
//   nReset       asynchronous active-low reset
//   in_wave      asynchronous measured signal (mux out_wave)
//   start        request a measurement, sampled only in IDLE
//   abort        cancel a measurement in SETTLE or GATE
//   gate_cycles  gate length in Clock cycles, latched on accepted start
//   busy         high while in SETTLE or GATE
//   done         one-cycle pulse when freq_count/overflow are updated
//   freq_count   rising edges counted in the last completed gate
//   overflow     last completed gate saturated the counter
module freq_gate_counter #(
  parameter int COUNT_WIDTH = 24,
  parameter int GATE_WIDTH  = 32
) (
  input  logic                   Clock,
  input  logic                   nReset,
  input  logic                   in_wave,
  input  logic                   start,
  input  logic                   abort,
  input  logic [GATE_WIDTH-1:0]  gate_cycles,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] freq_count,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_next;

  // Synchroniser and edge history
  logic s1, s2, prev;
  logic rise;

  // Measurement datapath
  logic                   settle_cnt, settle_next;
  logic [GATE_WIDTH-1:0]  timer, timer_next;
  logic [COUNT_WIDTH-1:0] cnt, cnt_next;
  logic                   acc, acc_next;
  logic                   load_result;

  // Registered output decode
  logic busy_next, done_next;

  assign rise = s2 & ~prev;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= in_wave;
      s2   <= s1;
      prev <= s2;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      settle_cnt <= 1'b0;
      timer      <= '0;
      cnt        <= '0;
      acc        <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
      timer      <= timer_next;
      cnt        <= cnt_next;
      acc        <= acc_next;
    end
  end

  // busy/done are decoded from the next state and registered so that they
  // line up with the state they describe without a combinational path.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      freq_count <= '0;
      overflow   <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
      if (load_result) begin
        // Load the post-update values so a rise in the final gate cycle counts.
        freq_count <= cnt_next;
        overflow   <= acc_next;
      end
    end
  end

  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    timer_next  = timer;
    cnt_next    = cnt;
    acc_next    = acc;
    load_result = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_next  = SETTLE;
          settle_next = 1'b0;
          timer_next  = gate_cycles;
          cnt_next    = '0;
          acc_next    = 1'b0;
        end
      end

      SETTLE: begin
        // Two cycles flush stale synchroniser state after a channel change.
        if (abort) begin
          state_next = IDLE;
        end else if (settle_cnt) begin
          if (timer == '0) begin
            state_next  = DONE;
            load_result = 1'b1;
          end else begin
            state_next = GATE;
          end
        end else begin
          settle_next = 1'b1;
        end
      end

      GATE: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          if (rise) begin
            if (cnt == '1) acc_next = 1'b1;
            else           cnt_next = cnt + COUNT_WIDTH'(1);
          end
          timer_next = timer - GATE_WIDTH'(1);
          if (timer == GATE_WIDTH'(1)) begin
            state_next  = DONE;
            load_result = 1'b1;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    busy_next = (state_next == SETTLE) || (state_next == GATE);
    done_next = (state_next == DONE);
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
`timescale 1ns/1ps
module tb_freq_gate_counter;
  localparam int CW   = 8;
  localparam int GW   = 32;
  localparam int MAXC = 32768;

  logic          Clock = 1'b0;
  logic          nReset = 1'b0;
  logic          in_wave = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [GW-1:0] gate_cycles = '0;
  logic          busy, done, overflow;
  logic [CW-1:0] freq_count;

  freq_gate_counter #(.COUNT_WIDTH(CW), .GATE_WIDTH(GW)) dut (
    .Clock(Clock), .nReset(nReset), .in_wave(in_wave), .start(start),
    .abort(abort), .gate_cycles(gate_cycles), .busy(busy), .done(done),
    .freq_count(freq_count), .overflow(overflow)
  );

  always #10 Clock = ~Clock;

  typedef struct {
    int unsigned count;
    bit          ovf;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          vecs = 0;
  int          errs = 0;
  int unsigned cyc = 0;
  bit          wave_plan[MAXC];
  int unsigned last_count = 0;
  bit          last_ovf = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  // Pin driver: in cycle c the pin carries wave_plan[c].
  initial begin
    forever begin
      @(posedge Clock);
      cyc++;
      #1;
      if (cyc < MAXC) in_wave = wave_plan[cyc];
    end
  end

  // Reference: rising pin transitions during the N cycles after the start cycle.
  function automatic exp_t model(input int unsigned t, input int unsigned n);
    exp_t        e;
    int unsigned raw = 0;
    int unsigned maxv = (1 << CW) - 1;
    for (int unsigned j = t + 1; j <= t + n; j++)
      if (wave_plan[j] && !wave_plan[j-1]) raw++;
    e.count = (raw > maxv) ? maxv : raw;
    e.ovf   = (raw > maxv);
    e.cyc   = t + 3 + n;
    return e;
  endfunction

  task automatic plan(input int unsigned t, input int unsigned n,
                      input int unsigned hmin, input int unsigned hmax, input bit hold);
    bit          lvl = wave_plan[t];
    int unsigned k = t + 1;
    int unsigned last = t + n + 8;
    int unsigned len = $urandom_range(hmax, 1);
    if (last >= MAXC) last = MAXC - 1;
    while (k <= last) begin
      if (hold) begin
        wave_plan[k] = 1'b1;
        k++;
      end else begin
        for (int unsigned i = 0; i < len && k <= last; i++) begin
          wave_plan[k] = lvl;
          k++;
        end
        lvl = ~lvl;
        len = $urandom_range(hmax, hmin);
      end
    end
  endtask

  task automatic launch(input int unsigned n, input int unsigned hmin, input int unsigned hmax,
                        input bit hold, input bit with_abort, input bit expect_done,
                        output int unsigned t);
    exp_t e;
    @(posedge Clock); #3;
    t = cyc;
    gate_cycles = GW'(n);
    start = 1'b1;
    abort = with_abort;
    plan(t, n, hmin, hmax, hold);
    if (expect_done) begin
      e = model(t, n);
      sb.push_back(e);
      last_count = e.count;
      last_ovf   = e.ovf;
    end
    @(posedge Clock); #3;
    start = 1'b0;
    abort = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic finish_run(input int unsigned n);
    repeat (n + 3) @(posedge Clock);
    #3;
    chk("busy_after_done", busy, 0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (done) begin
        if (sb.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_done at cycle %0d: done=1, required no pulse", cyc);
        end else begin
          e = sb.pop_front();
          chk("freq_count", freq_count, e.count);
          chk("overflow", overflow, e.ovf);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned t, ct, n;
    repeat (3) @(posedge Clock);
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_count", freq_count, 0);
    chk("reset_overflow", overflow, 0);
    nReset = 1'b1;
    repeat (2) @(posedge Clock);

    // Basic: 10-cycle period, 1000-cycle gate
    launch(1000, 5, 5, 0, 0, 1, t);
    finish_run(1000);

    // Zero gate
    launch(0, 1, 4, 0, 0, 1, t);
    finish_run(0);

    // One-cycle gate with pin already high: no false edge
    @(posedge Clock); #3;
    ct = cyc;
    for (int unsigned k = ct + 1; k <= ct + 8; k++) wave_plan[k] = 1'b1;
    repeat (6) @(posedge Clock);
    launch(1, 1, 1, 1, 0, 1, t);
    finish_run(1);

    // Saturation then recovery
    launch(1100, 2, 2, 0, 0, 1, t);
    finish_run(1100);
    launch(20, 2, 2, 0, 0, 1, t);
    finish_run(20);

    // Abort at gate cycle 500 after a completed run
    launch(1000, 5, 5, 0, 0, 1, t);
    finish_run(1000);
    launch(1000, 5, 5, 0, 0, 0, t);
    repeat (501) @(posedge Clock);
    #3;
    abort = 1'b1;
    @(posedge Clock); #3;
    abort = 1'b0;
    chk("busy_after_abort", busy, 0);
    chk("count_kept_after_abort", freq_count, last_count);
    chk("ovf_kept_after_abort", overflow, last_ovf);
    repeat (600) @(posedge Clock);

    // start and abort together in IDLE: start wins
    launch(50, 1, 4, 0, 1, 1, t);
    finish_run(50);

    // Ignored start during GATE and in DONE, gate_cycles changed mid-gate
    launch(300, 1, 6, 0, 0, 1, t);
    repeat (99) @(posedge Clock);
    #3;
    start = 1'b1;
    gate_cycles = GW'(5);
    @(posedge Clock); #3;
    start = 1'b0;
    repeat (t + 303 - cyc) @(posedge Clock);
    #3;
    start = 1'b1;
    @(posedge Clock); #3;
    start = 1'b0;
    repeat (2) @(posedge Clock);
    #3;
    chk("no_restart_busy", busy, 0);

    // Asynchronous reset mid-GATE, off the clock grid
    launch(400, 1, 6, 0, 0, 0, t);
    repeat (200) @(posedge Clock);
    #12;
    nReset = 1'b0;
    #2;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_count", freq_count, 0);
    chk("arst_overflow", overflow, 0);
    #1;
    nReset = 1'b1;
    last_count = 0;
    last_ovf = 1'b0;
    repeat (3) @(posedge Clock);
    #3;
    chk("idle_after_arst", busy, 0);
    repeat (400) @(posedge Clock);
    launch(150, 1, 6, 0, 0, 1, t);
    finish_run(150);

    // Randomised runs
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(300, 0);
      launch(n, 1, $urandom_range(6, 1), 0, 1'($urandom_range(1, 0)), 1, t);
      finish_run(n);
    end

    repeat (10) @(posedge Clock);
    #3;
    if (sb.size() != 0) begin
      vecs++;
      errs++;
      $display("FAIL missing_done: %0d expected results outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
